// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the timer_dev register block
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] IDX_CTRL   = 2'd0;
  localparam logic [1:0] IDX_PRESET = 2'd1;
  localparam logic [1:0] IDX_COUNT  = 2'd2;
  localparam logic [1:0] IDX_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PEND    = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped down-counter with preset, auto-reload and masked interrupt
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic        pend_q, pend_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;

  logic        sel;
  logic [1:0]  idx;
  logic        wr;
  logic        set_pend;
  logic        fsm_clr_en;

  assign sel = (addr[31:4] == BASE[31:4]);
  assign idx = addr[3:2];
  assign wr  = sel && we && (byteen != 4'b0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      pend_q   <= pend_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  // Counter sequencing; only the reload mode restarts, every other MODE code is one-shot.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    set_pend   = 1'b0;
    fsm_clr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q == 32'd0) begin
          state_d  = ST_INT;
          set_pend = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (mode_q == MODE_RELOAD) begin
          state_d = ST_LOAD;
        end else begin
          state_d    = ST_IDLE;
          fsm_clr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file; the FSM's pending set is applied last so it beats a same-edge CTRL clear.
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    pend_d   = pend_q;
    preset_d = preset_q;
    if (wr && idx == IDX_CTRL) begin
      if (byteen[0]) begin
        en_d   = wdata[CTRL_EN];
        mode_d = wdata[CTRL_MODE_HI:CTRL_MODE_LO];
        im_d   = wdata[CTRL_IM];
      end
      pend_d = 1'b0;
    end
    if (wr && idx == IDX_PRESET) begin
      for (int i = 0; i < 4; i++) begin
        if (byteen[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    if (fsm_clr_en) en_d = 1'b0;
    if (set_pend) pend_d = 1'b1;
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (idx)
        IDX_CTRL:   rdata = {27'd0, pend_q, im_q, mode_q, en_q};
        IDX_PRESET: rdata = preset_q;
        IDX_COUNT:  rdata = count_q;
        IDX_RSVD:   rdata = 32'd0;
        default:    rdata = 32'd0;
      endcase
    end
  end

  assign irq = pend_q & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - directed self-checking bench for timer_dev
module tb_timer_dev;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks;
  int errors;

  timer_dev #(.BASE(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_abs(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    addr   = a;
    byteen = be;
    wdata  = d;
    we     = 1'b1;
    tick();
    we     = 1'b0;
    byteen = 4'b0000;
  endtask

  task automatic wr(input logic [3:0] off, input logic [3:0] be, input logic [31:0] d);
    wr_abs(BASE + {28'd0, off}, be, d);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic seen_irq;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    addr   = BASE;
    we     = 1'b0;
    byteen = 4'b0000;
    wdata  = 32'd0;

    // reset state
    do_reset();
    rd_chk("rst_ctrl",   BASE + 32'h0, 32'h0);
    rd_chk("rst_preset", BASE + 32'h4, 32'h0);
    rd_chk("rst_count",  BASE + 32'h8, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // one-shot, PRESET=3, IM=1: irq at edge 6 after the CTRL write
    wr(4'h4, 4'hF, 32'd3);
    wr(4'h0, 4'hF, 32'h9);
    tick();
    tick();
    rd_chk("os_cnt_e2", BASE + 32'h8, 32'd3);
    tick();
    rd_chk("os_cnt_e3", BASE + 32'h8, 32'd2);
    tick();
    rd_chk("os_cnt_e4", BASE + 32'h8, 32'd1);
    tick();
    rd_chk("os_cnt_e5", BASE + 32'h8, 32'd0);
    chk("os_irq_e5", {31'd0, irq}, 32'd0);
    tick();
    chk("os_irq_e6", {31'd0, irq}, 32'd1);
    rd_chk("os_ctrl_e6", BASE + 32'h0, 32'h19);
    tick();
    rd_chk("os_ctrl_e7", BASE + 32'h0, 32'h18);
    tick();
    tick();
    chk("os_irq_hold", {31'd0, irq}, 32'd1);
    wr(4'h0, 4'hF, 32'h8);
    chk("os_irq_clr", {31'd0, irq}, 32'd0);

    // auto-reload, PRESET=2, CTRL=0xB: irq every 5 edges
    do_reset();
    wr(4'h4, 4'hF, 32'd2);
    wr(4'h0, 4'hF, 32'hB);
    tick(); tick(); tick(); tick();
    chk("ar_irq_e4", {31'd0, irq}, 32'd0);
    tick();
    chk("ar_irq_e5", {31'd0, irq}, 32'd1);
    tick();
    rd_chk("ar_cnt_e6", BASE + 32'h8, 32'd0);
    tick();
    rd_chk("ar_cnt_e7", BASE + 32'h8, 32'd2);
    wr(4'h0, 4'h1, 32'hB);
    chk("ar_irq_clr", {31'd0, irq}, 32'd0);
    rd_chk("ar_cnt_e8", BASE + 32'h8, 32'd1);
    tick();
    rd_chk("ar_cnt_e9", BASE + 32'h8, 32'd0);
    // CTRL write on the CNT->INT edge: the pending set wins
    wr(4'h0, 4'hF, 32'hB);
    chk("ar_set_wins", {31'd0, irq}, 32'd1);

    // masked: IM=0, PRESET=0
    do_reset();
    wr(4'h4, 4'hF, 32'd0);
    wr(4'h0, 4'hF, 32'h1);
    tick(); tick(); tick(); tick();
    rd_chk("mk_ctrl", BASE + 32'h0, 32'h10);
    chk("mk_irq", {31'd0, irq}, 32'd0);
    wr(4'h0, 4'hF, 32'h8);
    rd_chk("mk_ctrl_clr", BASE + 32'h0, 32'h08);
    chk("mk_irq_clr", {31'd0, irq}, 32'd0);

    // stop mid-count, then partial PRESET write
    do_reset();
    wr(4'h4, 4'hF, 32'd10);
    wr(4'h0, 4'hF, 32'h1);
    tick(); tick(); tick(); tick();
    rd_chk("st_cnt_e4", BASE + 32'h8, 32'd8);
    wr(4'h0, 4'hF, 32'h0);
    tick(); tick(); tick();
    rd_chk("st_cnt_frozen", BASE + 32'h8, 32'd7);
    wr(4'h4, 4'b0010, 32'hAABB_CCDD);
    rd_chk("st_preset_be", BASE + 32'h4, 32'h0000_CC0A);

    // ignored writes: COUNT, reserved, outside window
    wr(4'hC, 4'hF, 32'hFFFF_FFFF);
    wr(4'h8, 4'hF, 32'hFFFF_FFFF);
    wr_abs(32'h0000_7F10, 4'hF, 32'hFFFF_FFFF);
    tick();
    rd_chk("ig_ctrl",   BASE + 32'h0, 32'h0);
    rd_chk("ig_preset", BASE + 32'h4, 32'h0000_CC0A);
    rd_chk("ig_count",  BASE + 32'h8, 32'd7);
    tick();
    rd_chk("ig_rsvd",   BASE + 32'hC, 32'h0);
    rd_chk("ig_outside", 32'h0000_7F14, 32'h0);

    // reset mid-count, colliding with a PRESET write
    do_reset();
    wr(4'h4, 4'hF, 32'd10);
    wr(4'h0, 4'hF, 32'h9);
    tick(); tick(); tick(); tick(); tick(); tick(); tick();
    rd_chk("rm_cnt_5", BASE + 32'h8, 32'd5);
    reset  = 1'b1;
    addr   = BASE + 32'h4;
    byteen = 4'hF;
    wdata  = 32'h55;
    we     = 1'b1;
    tick();
    we     = 1'b0;
    byteen = 4'h0;
    reset  = 1'b0;
    rd_chk("rm_ctrl",   BASE + 32'h0, 32'h0);
    rd_chk("rm_preset", BASE + 32'h4, 32'h0);
    rd_chk("rm_count",  BASE + 32'h8, 32'h0);
    seen_irq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_irq = seen_irq | irq;
    end
    chk("rm_no_irq", {31'd0, seen_irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_7F00, the word-aligned base address of the 16-byte register window.
REQ-002 SHALL have ports, one per line:
  clk      in   1   clock, all state updates on rising edge
  reset    in   1   synchronous, active-high reset
  addr     in   32  CPU data-bus byte address
  we       in   1   CPU write strobe
  byteen   in   4   per-byte write enables, bit i -> wdata[8i+7:8i]
  wdata    in   32  write data
  rdata    out  32  read data, combinational from addr
  irq      out  1   interrupt request to CPU, level
REQ-003 Reset SHALL be reset, synchronous, active-high; clock SHALL be clk.

Function
REQ-004 Select: addr[31:4] == BASE[31:4]; word index = addr[3:2]; 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
REQ-005 Write SHALL occur on the rising edge when select, we and byteen != 0 all hold; only enabled bytes are updated.
REQ-006 CTRL write bits: [0] EN, [2:1] MODE, [3] IM; other write bits ignored; MODE 2'b10/2'b11 SHALL behave as 2'b00.
REQ-007 CTRL read SHALL return {27'b0, PEND, IM, MODE, EN}; PRESET reads its 32-bit value; COUNT reads the counter; reserved index and unselected addr read 0.
REQ-008 Writes to COUNT and reserved index SHALL be ignored.
REQ-009 Any write to CTRL, with any nonzero byteen, SHALL clear PEND on that edge.
REQ-010 FSM states: IDLE, LOAD, CNT, INT.
REQ-011 IDLE -> LOAD when registered EN = 1; otherwise IDLE.
REQ-012 LOAD: COUNT <= PRESET pre-write value on that edge; -> CNT.
REQ-013 CNT: if EN = 0 -> IDLE with COUNT frozen; else if COUNT == 0 -> INT and PEND <= 1; else COUNT <= COUNT - 1.
REQ-014 INT: MODE 00 -> IDLE and EN <= 0; MODE 01 -> LOAD with EN kept.
REQ-015 When a CTRL write clearing EN coincides with INT in MODE 00, EN SHALL be 0 and PEND SHALL be 0.
REQ-016 When a CTRL write coincides with the CNT -> INT transition, PEND SHALL end at 1; the set wins.
REQ-017 Counting SHALL be unsigned 32-bit; COUNT never wraps below 0.
REQ-018 irq SHALL equal PEND & IM, registered-source; toggling IM masks or unmasks without losing PEND.
REQ-019 With PRESET = N, irq SHALL rise (IM = 1) N+3 rising edges after the CTRL-write edge that sets EN.

Reset
REQ-020 On reset: state IDLE; CTRL, PRESET, COUNT, PEND = 0; irq = 0. Reset SHALL take priority over a simultaneous write.
REQ-021 Reset in any state, including mid-count, SHALL abandon the count with no irq.

Structure
REQ-022 Package timer_pkg SHALL hold the state enum, word-index constants, CTRL bit positions and MODE codes.
REQ-023 The block SHALL be a single module with no sub-modules; the register file and FSM are in one always block per concern.

Verification
REQ-024 Write PRESET = 3, then CTRL = 0x9 -> COUNT reads 3, 2, 1, 0; irq rises at edge 6 after the CTRL write; EN reads 0; irq stays high until a CTRL write.
REQ-025 PRESET = 2, CTRL = 0xB (auto-reload, IM) -> irq after 5 edges; COUNT reloads to 2 and repeats; CTRL write clears irq while counting continues.
REQ-026 CTRL = 0x1 (IM = 0), PRESET = 0 -> PEND reads 1 and irq stays 0; a write of CTRL with IM = 1 clears PEND, so irq stays 0.
REQ-027 Mid-count CTRL = 0x0 -> state IDLE, COUNT frozen at its current value; byteen = 4'b0010 write to PRESET updates only bits [15:8].
REQ-028 Assert reset at COUNT = 5 -> all registers read 0 the next cycle; irq never asserts.
REQ-029 Write to BASE+0xC and to BASE+0x8, and a write with addr outside the window -> no register changes; reads return 0 except COUNT.
